store_coalescer: RTL and testbench
==================================

# store_coalescer

Write-combining stage between the store buffer's commit-queue output and the data-cache store port. It merges committed, non-speculative stores that fall in the same cache-line-sized window into one byte-masked entry. It drains that entry to the D$ as one write per dirty word. This cuts D$ store-port occupancy for sequential byte and half-word stores. The LSU must treat the block as part of the store path: `empty_o` gates fences and AMOs, and `page_offset_matches_o` stalls conflicting loads.

## Interface
Parameters:
- `PLEN`, 56: physical address width.
- `XLEN`, 64: word width in bits. Word = XLEN/8 bytes.
- `LINE_WORDS`, 2: words per coalescing window. Power of 2, ≥2.
- `TIMEOUT`, 16: idle cycles before forced drain. Range ≥2.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `in_req_i` in 1: committed store valid (from store buffer `data_req`).
- `in_gnt_o` out 1: store accepted this cycle.
- `in_addr_i` in PLEN: store physical address, word-aligned.
- `in_data_i` in XLEN: store data.
- `in_be_i` in XLEN/8: byte enables.
- `drain_i` in 1: force drain and block new stores (fence, AMO, flush).
- `page_offset_i` in 12: load page offset to check.
- `page_offset_matches_o` out 1: held dirty word matches `page_offset_i[11:3]`.
- `empty_o` out 1: no data held.
- `out_req_o` out 1: D$ write request.
- `out_gnt_i` in 1: D$ grant.
- `out_addr_o` out PLEN: word-aligned write address.
- `out_data_o` out XLEN: write data.
- `out_be_o` out XLEN/8: write byte enables.

## Operation
Field widths:
- OFS = log2(XLEN/8).
- WIDX = log2(LINE_WORDS).
- Line tag = `in_addr_i[PLEN-1:OFS+WIDX]`.
- Word index = `in_addr_i[OFS+WIDX-1:OFS]`.

State: one entry holding the tag, LINE_WORDS data words, and a per-byte valid mask.

FSM states:
- **IDLE**:
  - Entry empty, `empty_o`=1.
  - `in_gnt_o` = `in_req_i & !drain_i`.
  - On grant: load tag, write data bytes under `in_be_i`, set mask bits, go to FILL.
- **FILL**:
  - Same-tag request and `!drain_i`: grant in the same cycle. Merge bytes with the newer store overwriting, OR the mask, clear the idle counter.
  - Different-tag request: no grant, go to DRAIN. The request is retried by the store buffer.
  - `drain_i`: no grant, go to DRAIN.
  - Mask all-ones after the update: go to DRAIN.
  - Timeout (see Configuration): go to DRAIN.
- **DRAIN**:
  - The word counter points at the lowest word with a nonzero mask. Words with an all-zero mask are skipped with no cycle cost.
  - `out_req_o`=1. Address = `{tag, widx, OFS'b0}`; data and be come from that word.
  - On `out_gnt_i`: clear that word's mask and advance the counter.
  - After the last dirty word is granted, go to IDLE.
  - `in_gnt_o`=0 throughout DRAIN.

Page-offset match: asserted when some word w has a nonzero mask and `{tag,w}` address bits [11:3] equal `page_offset_i[11:3]`. Combinational, any state.

Idle counter:
- Increments each FILL cycle with no grant.
- Saturates at TIMEOUT-1.
- Cleared on every grant and on entry to IDLE.

## Timing
- Reset:
  - State IDLE, mask 0, counters 0.
  - Outputs: `in_gnt_o`=0 (while `in_req_i`=0), `out_req_o`=0, `empty_o`=1, `page_offset_matches_o`=0, `out_addr_o`/`out_data_o`/`out_be_o`=0.
- Reset mid-DRAIN discards all held data. No partial write is guaranteed.
- Input handshake:
  - `in_gnt_o` is combinational from `in_req_i`, `in_addr_i`, `drain_i` and state.
  - Accepted data is visible in the entry the next cycle.
- Output handshake:
  - Moore style. `out_req_o`, `out_addr_o`, `out_data_o` and `out_be_o` depend only on registers, never on `out_gnt_i`.
  - Outputs stay stable until granted.
  - One word per grant. A back-to-back grant drains a full 2-word line in 2 cycles.
- Latency, FILL→DRAIN: the transition is registered, so `out_req_o` rises the cycle after the trigger.
- `empty_o` falls the cycle after the first grant. It rises the cycle after the last `out_gnt_i`.
- Simultaneous events:
  - `drain_i` has priority over merge.
  - A full-line transition and a timeout in the same cycle both go to DRAIN once.

## Configuration
- `STORE_COALESCER_TIMEOUT_EN` defined: the FILL idle counter is present. When it reaches TIMEOUT-1 with no grant that cycle, the FSM goes to DRAIN.
- Not defined: the counter logic is removed. FILL is left only on a tag mismatch, a full mask, or `drain_i`. `TIMEOUT` is ignored.

## Test plan
- Reset, then check outputs:
  - `empty_o`=1, `out_req_o`=0.
- Merge within one line:
  - Stores 0x1000 be=0x0F data=0x11111111 and 0x1000 be=0xF0 data=0x22222222_00000000 are both granted.
  - Then `drain_i`: exactly one write to 0x1000, be=0xFF, data=0x22222222_11111111.
- Tag conflict:
  - Store 0x1008 be=0x01 is held. Store 0x2000 gets `in_gnt_o`=0.
  - One write to 0x1008 occurs (word 0 skipped). Then 0x2000 is granted, from IDLE.
- Full line:
  - 0x3000 be=0xFF and 0x3008 be=0xFF are granted.
  - `out_req_o` rises the next cycle. Writes go to 0x3000 then 0x3008 with `out_gnt_i` held high. IDLE after 2 cycles.
- Timeout with macro, TIMEOUT=4:
  - One store, then idle. `out_req_o` asserts 4 cycles after the grant.
  - Without the macro, no request after 100 cycles.
- Stall and page-offset match:
  - Hold 0x4010. `page_offset_i`=0x010 gives match=1; 0x018 gives 0.
  - Hold `out_gnt_i`=0 for 5 cycles in DRAIN. Outputs stay stable and `in_gnt_o`=0.

Source files
------------

// File: rtl/store_coalescer.sv
// Write-combining stage between the store buffer and the D$ store port.
// Optional FILL idle timeout is compiled in with `define STORE_COALESCER_TIMEOUT_EN.
module store_coalescer #(
   parameter int unsigned PLEN       = 56,
   parameter int unsigned XLEN       = 64,
   parameter int unsigned LINE_WORDS = 2,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_req_i,
   output logic              in_gnt_o,
   input  logic [PLEN-1:0]   in_addr_i,
   input  logic [XLEN-1:0]   in_data_i,
   input  logic [XLEN/8-1:0] in_be_i,
   input  logic              drain_i,
   input  logic [11:0]       page_offset_i,
   output logic              page_offset_matches_o,
   output logic              empty_o,
   output logic              out_req_o,
   input  logic              out_gnt_i,
   output logic [PLEN-1:0]   out_addr_o,
   output logic [XLEN-1:0]   out_data_o,
   output logic [XLEN/8-1:0] out_be_o
);

   localparam int unsigned NB   = XLEN / 8;
   localparam int unsigned OFS  = $clog2(NB);
   localparam int unsigned WIDX = $clog2(LINE_WORDS);
   localparam int unsigned TAGW = PLEN - OFS - WIDX;

   typedef enum logic [1:0] {StIdle, StFill, StDrain} state_e;

   state_e                            state_q, state_d;
   logic [TAGW-1:0]                   tag_q, tag_d;
   logic [LINE_WORDS-1:0][XLEN-1:0]   data_q, data_d;
   logic [LINE_WORDS-1:0][NB-1:0]     mask_q, mask_d;

   logic [TAGW-1:0]                   in_tag;
   logic [WIDX-1:0]                   in_widx;
   logic                              tag_hit;
   logic [LINE_WORDS-1:0][XLEN-1:0]   data_merge;
   logic [LINE_WORDS-1:0][NB-1:0]     mask_merge;
   logic [WIDX-1:0]                   drain_idx;
   logic                              any_dirty;
   logic                              rest_dirty;
   logic                              timeout_hit;
   logic                              unused_bits;

   assign in_tag      = in_addr_i[PLEN-1:OFS+WIDX];
   assign in_widx     = in_addr_i[OFS+WIDX-1:OFS];
   assign tag_hit     = (in_tag == tag_q);
   assign unused_bits = ^{page_offset_i[2:0], in_addr_i[OFS-1:0]};

   // Entry contents with the incoming store folded in; newer bytes win.
   always_comb begin
      data_merge = data_q;
      mask_merge = mask_q;
      for (int w = 0; w < LINE_WORDS; w++) begin
         if (WIDX'(w) == in_widx) begin
            mask_merge[w] = mask_q[w] | in_be_i;
            for (int b = 0; b < NB; b++) begin
               if (in_be_i[b]) begin
                  data_merge[w][8*b +: 8] = in_data_i[8*b +: 8];
               end
            end
         end
      end
   end

   // Lowest dirty word is the next one to drain; clean words cost nothing.
   always_comb begin
      drain_idx  = '0;
      any_dirty  = 1'b0;
      rest_dirty = 1'b0;
      for (int w = LINE_WORDS - 1; w >= 0; w--) begin
         if (|mask_q[w]) begin
            drain_idx = WIDX'(w);
            any_dirty = 1'b1;
         end
      end
      for (int w = 0; w < LINE_WORDS; w++) begin
         if ((|mask_q[w]) && (WIDX'(w) != drain_idx)) begin
            rest_dirty = 1'b1;
         end
      end
   end

`ifdef STORE_COALESCER_TIMEOUT_EN
   localparam int unsigned CNTW = $clog2(TIMEOUT);

   logic [CNTW-1:0] idle_cnt_q, idle_cnt_d;

   // Fires in the cycle whose increment brings the count to TIMEOUT-1.
   assign timeout_hit = (idle_cnt_q >= CNTW'(TIMEOUT - 2));

   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if ((state_q != StFill) || in_gnt_o) begin
         idle_cnt_d = '0;
      end else if (idle_cnt_q != CNTW'(TIMEOUT - 1)) begin
         idle_cnt_d = idle_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end
`else
   // TIMEOUT >= 2, so this is a constant 0 with no counter behind it.
   assign timeout_hit = (TIMEOUT == 0);
`endif

   always_comb begin
      state_d  = state_q;
      tag_d    = tag_q;
      data_d   = data_q;
      mask_d   = mask_q;
      in_gnt_o = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_gnt_o = in_req_i & ~drain_i;
            if (in_gnt_o) begin
               tag_d   = in_tag;
               data_d  = data_merge;
               mask_d  = mask_merge;
               state_d = StFill;
            end
         end
         StFill: begin
            if (drain_i) begin
               state_d = StDrain;
            end else if (in_req_i && !tag_hit) begin
               state_d = StDrain;
            end else if (in_req_i) begin
               in_gnt_o = 1'b1;
               data_d   = data_merge;
               mask_d   = mask_merge;
               if (&mask_merge) begin
                  state_d = StDrain;
               end
            end else if (timeout_hit) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (!any_dirty) begin
               state_d = StIdle;
            end else if (out_gnt_i) begin
               mask_d[drain_idx] = '0;
               if (!rest_dirty) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         tag_q   <= '0;
         data_q  <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
      end
   end

   always_comb begin
      logic [PLEN-1:0] waddr;
      waddr                 = '0;
      page_offset_matches_o = 1'b0;
      for (int w = 0; w < LINE_WORDS; w++) begin
         waddr = {tag_q, WIDX'(w), {OFS{1'b0}}};
         if ((|mask_q[w]) && (waddr[11:3] == page_offset_i[11:3])) begin
            page_offset_matches_o = 1'b1;
         end
      end
   end

   assign empty_o    = (state_q == StIdle);
   assign out_req_o  = (state_q == StDrain) && any_dirty;
   assign out_addr_o = out_req_o ? {tag_q, drain_idx, {OFS{1'b0}}} : '0;
   assign out_data_o = out_req_o ? data_q[drain_idx] : '0;
   assign out_be_o   = out_req_o ? mask_q[drain_idx] : '0;

endmodule

// File: tb/tb_store_coalescer.sv
// Self-checking bench for store_coalescer: directed cases plus randomized stores
// checked against a line-buffer reference model.
module tb_store_coalescer;

   localparam int PLEN = 56;
   localparam int XLEN = 64;
   localparam int LW   = 2;
   localparam int NB   = 8;
   localparam int TMO  = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_req_i;
   logic            in_gnt_o;
   logic [PLEN-1:0] in_addr_i;
   logic [XLEN-1:0] in_data_i;
   logic [NB-1:0]   in_be_i;
   logic            drain_i;
   logic [11:0]     page_offset_i;
   logic            page_offset_matches_o;
   logic            empty_o;
   logic            out_req_o;
   logic            out_gnt_i;
   logic [PLEN-1:0] out_addr_o;
   logic [XLEN-1:0] out_data_o;
   logic [NB-1:0]   out_be_o;

   store_coalescer #(
      .PLEN       (PLEN),
      .XLEN       (XLEN),
      .LINE_WORDS (LW),
      .TIMEOUT    (TMO)
   ) dut (
      .clk_i                 (clk),
      .rst_i                 (rst),
      .in_req_i              (in_req_i),
      .in_gnt_o              (in_gnt_o),
      .in_addr_i             (in_addr_i),
      .in_data_i             (in_data_i),
      .in_be_i               (in_be_i),
      .drain_i               (drain_i),
      .page_offset_i         (page_offset_i),
      .page_offset_matches_o (page_offset_matches_o),
      .empty_o               (empty_o),
      .out_req_o             (out_req_o),
      .out_gnt_i             (out_gnt_i),
      .out_addr_o            (out_addr_o),
      .out_data_o            (out_data_o),
      .out_be_o              (out_be_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PLEN-1:0] addr;
      logic [XLEN-1:0] data;
      logic [NB-1:0]   be;
   } wr_t;

   int checks = 0;
   int errors = 0;

   // Reference model: one line buffer, flushed as a list of expected writes.
   wr_t             exp_q[$];
   logic [PLEN-1:0] m_base;
   logic [XLEN-1:0] m_data[LW];
   logic [NB-1:0]   m_be[LW];

   int              wr_cnt = 0;
   logic [PLEN-1:0] last_addr;
   logic [XLEN-1:0] last_data;
   logic [NB-1:0]   last_be;
   logic            gnt_rand = 1'b0;
   logic            gnt_force = 1'b1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [XLEN-1:0] bytemask(input logic [NB-1:0] be);
      logic [XLEN-1:0] m;
      for (int b = 0; b < NB; b++) m[8*b +: 8] = {8{be[b]}};
      return m;
   endfunction

   function automatic bit model_any();
      for (int w = 0; w < LW; w++) if (m_be[w] != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_flush();
      wr_t t;
      for (int w = 0; w < LW; w++) begin
         if (m_be[w] != 0) begin
            t.addr = m_base + PLEN'(w * NB);
            t.data = m_data[w];
            t.be   = m_be[w];
            exp_q.push_back(t);
            m_be[w] = '0;
         end
      end
   endtask

   task automatic model_store(input logic [PLEN-1:0] a, input logic [XLEN-1:0] d,
                              input logic [NB-1:0] be);
      logic [PLEN-1:0] base;
      int              w;
      bit              full;
      base = a - (a % PLEN'(LW * NB));
      w    = int'((a / PLEN'(NB)) % PLEN'(LW));
      if (model_any() && base != m_base) model_flush();
      m_base = base;
      for (int b = 0; b < NB; b++) if (be[b]) m_data[w][8*b +: 8] = d[8*b +: 8];
      m_be[w] = m_be[w] | be;
      full = 1'b1;
      for (int i = 0; i < LW; i++) if (m_be[i] != 8'hFF) full = 1'b0;
      if (full) model_flush();
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic store(input logic [PLEN-1:0] a, input logic [XLEN-1:0] d,
                        input logic [NB-1:0] be, output int waits, output logic idle_at_gnt);
      logic        g;
      bit          po_chk;
      logic        po_exp;
      logic [11:0] po;
      logic [PLEN-1:0] wa;
      g = 1'b0; waits = 0; idle_at_gnt = 1'b0; po_exp = 1'b0;
      po_chk = model_any();
      po = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 1) == 1) po = 12'(m_base + PLEN'(NB * $urandom_range(0, LW - 1)));
      for (int w = 0; w < LW; w++) begin
         wa = m_base + PLEN'(w * NB);
         if (m_be[w] != 0 && (wa[11:3] == po[11:3])) po_exp = 1'b1;
      end
      page_offset_i = po;
      model_store(a, d, be);
      in_req_i = 1'b1; in_addr_i = a; in_data_i = d; in_be_i = be;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (i == 0 && po_chk) chk("page_match_rand", 64'(page_offset_matches_o), 64'(po_exp));
         if (in_gnt_o) begin
            g = 1'b1;
            idle_at_gnt = empty_o;
         end else begin
            waits++;
         end
         @(posedge clk); #1;
         if (g) break;
      end
      in_req_i = 1'b0;
      chk("store_granted", 64'(g), 64'(1));
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (empty_o) break;
      end
      chk("wait_empty", 64'(empty_o), 64'(1));
      @(posedge clk); #1;
   endtask

   task automatic drain();
      @(posedge clk); #1;
      drain_i = 1'b1;
      @(posedge clk); #1;
      drain_i = 1'b0;
      model_flush();
      wait_empty();
   endtask

   always @(posedge clk) begin
      #1;
      out_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : gnt_force;
   end

   // Write monitor: every granted write must match the model, stalls must hold.
   wr_t             e;
   logic            prev_stall = 1'b0;
   logic [PLEN-1:0] prev_addr;
   logic [XLEN-1:0] prev_data;
   logic [NB-1:0]   prev_be;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (out_req_o) chk("in_gnt_during_drain", 64'(in_gnt_o), 64'(0));
         if (prev_stall) begin
            chk("stall_req", 64'(out_req_o), 64'(1));
            chk("stall_addr", 64'(out_addr_o), 64'(prev_addr));
            chk("stall_data", out_data_o, prev_data);
            chk("stall_be", 64'(out_be_o), 64'(prev_be));
         end
         if (out_req_o && out_gnt_i) begin
            wr_cnt++;
            last_addr = out_addr_o; last_data = out_data_o; last_be = out_be_o;
            checks++;
            assert (exp_q.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_write: observed write to %h, expected none", out_addr_o);
            end
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("wr_addr", 64'(out_addr_o), 64'(e.addr));
               chk("wr_be", 64'(out_be_o), 64'(e.be));
               chk("wr_data", out_data_o & bytemask(e.be), e.data & bytemask(e.be));
            end
         end
         prev_stall = out_req_o && !out_gnt_i;
         prev_addr = out_addr_o; prev_data = out_data_o; prev_be = out_be_o;
      end
   end

   initial begin
      int              waits;
      int              n0;
      int              k;
      logic            idl;
      logic [PLEN-1:0] a;
      logic [NB-1:0]   be;

      for (int w = 0; w < LW; w++) begin m_be[w] = '0; m_data[w] = '0; end
      m_base = '0;
      rst = 1'b1; in_req_i = 1'b0; in_addr_i = '0; in_data_i = '0; in_be_i = '0;
      drain_i = 1'b0; page_offset_i = '0; out_gnt_i = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_empty", 64'(empty_o), 64'(1));
      chk("rst_out_req", 64'(out_req_o), 64'(0));
      chk("rst_in_gnt", 64'(in_gnt_o), 64'(0));
      chk("rst_match", 64'(page_offset_matches_o), 64'(0));
      chk("rst_out_addr", 64'(out_addr_o), 64'(0));
      chk("rst_out_data", out_data_o, 64'(0));
      chk("rst_out_be", 64'(out_be_o), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Merge within one word
      store(56'h1000, 64'h0000_0000_1111_1111, 8'h0F, waits, idl);
      chk("merge_gnt_a", 64'(waits), 64'(0));
      store(56'h1000, 64'h2222_2222_0000_0000, 8'hF0, waits, idl);
      chk("merge_gnt_b", 64'(waits), 64'(0));
      n0 = wr_cnt;
      drain();
      chk("merge_nwrites", 64'(wr_cnt - n0), 64'(1));
      chk("merge_addr", 64'(last_addr), 64'h1000);
      chk("merge_be", 64'(last_be), 64'hFF);
      chk("merge_data", last_data, 64'h2222_2222_1111_1111);

      // Tag conflict: old line drains (word 0 skipped), then new store from IDLE
      store(56'h1008, 64'h0000_0000_0000_00AB, 8'h01, waits, idl);
      n0 = wr_cnt;
      store(56'h2000, 64'h0123_4567_89AB_CDEF, 8'hFF, waits, idl);
      chk("conflict_waits", 64'(waits), 64'(2));
      chk("conflict_nwrites", 64'(wr_cnt - n0), 64'(1));
      chk("conflict_addr", 64'(last_addr), 64'h1008);
      chk("conflict_be", 64'(last_be), 64'h01);
      chk("conflict_from_idle", 64'(idl), 64'(1));
      drain();

      // Full line drains back-to-back
      store(56'h3000, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, waits, idl);
      store(56'h3008, 64'hBBBB_BBBB_BBBB_BBBB, 8'hFF, waits, idl);
      @(negedge clk);
      chk("full_req0", 64'(out_req_o), 64'(1));
      chk("full_addr0", 64'(out_addr_o), 64'h3000);
      @(negedge clk);
      chk("full_req1", 64'(out_req_o), 64'(1));
      chk("full_addr1", 64'(out_addr_o), 64'h3008);
      @(negedge clk);
      chk("full_idle", 64'(empty_o), 64'(1));
      chk("full_req_done", 64'(out_req_o), 64'(0));
      @(posedge clk); #1;

      // Idle timeout
      store(56'h5000, 64'h0000_0000_5555_5555, 8'h0F, waits, idl);
`ifdef STORE_COALESCER_TIMEOUT_EN
      model_flush();
      k = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (out_req_o) begin
            k = i;
            break;
         end
      end
      chk("timeout_latency", 64'(k), 64'(TMO));
      wait_empty();
`else
      k = 0;
      repeat (100) begin
         @(negedge clk);
         if (out_req_o) k++;
      end
      chk("no_timeout", 64'(k), 64'(0));
      drain();
`endif

      // Page-offset match and drain stall
      gnt_force = 1'b0;
      store(56'h4010, 64'hDEAD_BEEF_0123_4567, 8'hFF, waits, idl);
      page_offset_i = 12'h010;
      @(negedge clk);
      chk("po_match_hit", 64'(page_offset_matches_o), 64'(1));
      @(posedge clk); #1;
      page_offset_i = 12'h018;
      @(negedge clk);
      chk("po_match_miss", 64'(page_offset_matches_o), 64'(0));
      @(posedge clk); #1;
      drain_i = 1'b1;
      @(posedge clk); #1;
      drain_i = 1'b0;
      model_flush();
      in_req_i = 1'b1; in_addr_i = 56'h4000; in_be_i = 8'hFF;
      repeat (5) begin
         @(negedge clk);
         chk("stall_out_req", 64'(out_req_o), 64'(1));
         chk("stall_out_addr", 64'(out_addr_o), 64'h4010);
         chk("stall_out_be", 64'(out_be_o), 64'hFF);
         chk("stall_out_data", out_data_o, 64'hDEAD_BEEF_0123_4567);
         chk("stall_in_gnt", 64'(in_gnt_o), 64'(0));
      end
      in_req_i = 1'b0;
      gnt_force = 1'b1;
      wait_empty();

      // Randomized stores against the model
      gnt_rand = 1'b1;
      for (int n = 0; n < 300; n++) begin
         a  = 56'h8000 + PLEN'(16 * $urandom_range(0, 3)) + PLEN'(8 * $urandom_range(0, 1));
         be = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
         store(a, {$urandom, $urandom}, be, waits, idl);
         if ($urandom_range(0, 7) == 0) drain();
      end
      drain();
      chk("pending_writes", 64'(exp_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
